rr_grant_arbiter: RTL and testbench
===================================

Name: rr_grant_arbiter

Overview:
- Round-robin arbiter that shares one resource among 4 requesters.
- Outputs a registered one-hot grant, with the same 00→0001 … 11→1000 mapping as our 2-to-4 decoder, plus the 2-bit owner index.
- Grant hold is bounded by an explicit release, a dropped request, or a hold timeout.
- Sits between the 4 lab sub-units and a shared datapath/display resource; the downstream mux selects on grant_idx.

Parameters:
- MAX_HOLD, 16: max consecutive cycles one requester may hold grant; 0 disables timeout.
- CNT_W, $clog2(MAX_HOLD+1) (min 1): width of the hold counter. Derived; do not override.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request vector; bit i = requester i.
- done  input  1  current owner releases the resource; sampled only in GRANT.
- grant  output  4  registered one-hot grant; all-zero when no owner.
- grant_idx  output  2  index of the current owner; holds the last owner index when grant=0.
- grant_valid  output  1  equals |grant.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, grant=4'b0000, grant_idx=2'b00, grant_valid=0, timeout=0.
  - pointer=2'b00, hold_cnt=0.
- States: IDLE, GRANT. 1-bit encoding.
- IDLE:
  - If req==0: stay in IDLE, grant=0.
  - Else: select the first set bit of req, scanning circularly from pointer (pointer, pointer+1, … mod 4).
  - On the next edge: state=GRANT, grant_idx=selected, grant=decode(selected), hold_cnt=0.
  - Latency: req to grant is 1 clock edge.
- GRANT: exit to IDLE on the next edge if any of the following hold (priority order listed; all exits behave identically except timeout):
  a) done=1
  b) req[grant_idx]=0
  c) MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1
- Otherwise stay in GRANT and hold_cnt increments by 1, saturating at MAX_HOLD-1.
- On any exit:
  - grant=0 and pointer=grant_idx+1 (2-bit wrap: 3→0).
  - grant_idx holds its value.
- timeout=1 for the single IDLE cycle after an exit caused only by c). If a) or b) is also true on that cycle, timeout=0.
- Minimum one cycle with grant=0 between any two grants, including back-to-back grants to different requesters. The same requester can never be granted twice consecutively while another requester is asserting req.
- Only the owner's req bit affects GRANT. Changes on other bits are ignored until IDLE.
- done is ignored in IDLE.
- Fairness bound with MAX_HOLD=M: a waiting requester is granted within 3·(M+1)+1 cycles.
- grant is always one-hot or zero. No X on outputs after reset.
- Reset mid-grant: grant drops asynchronously in the same cycle; pointer returns to 0.
- Resource mapping: grant[i]=1 iff grant_idx==i and state==GRANT.

Test Plan:
1. Reset with req=4'b1111 → grant=0000 during rst. First edge after release: grant=0001, idx=0.
2. Rotation with req=1111 held and done pulsed each GRANT cycle → grant sequence 0001,0000,0010,0000,0100,0000,1000,0000,0001.
3. Timeout with MAX_HOLD=4, req=0100 held, done=0:
   - grant=0100 for exactly 4 cycles, then 0000 with timeout=1 for one cycle.
   - Regrant 0100 next cycle (sole requester).
4. Request drop: owner 2 granted, req goes 0100→1001 → next edge grant=0000 (no timeout). Following edge grant=1000 (pointer=3 beats requester 0).
5. Async reset while grant=0010 with a mid-cycle rst pulse → grant=0000 before the next clock edge. After rst deasserts with req=0110: grant=0010 (pointer reset to 0).
6. Timeout disabled with MAX_HOLD=0, req=0001, done=0 for 100 cycles → grant stays 0001, timeout never asserts, hold_cnt does not overflow.

Source files
------------

// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// rr_grant_arbiter : 4-requester round-robin arbiter, registered one-hot grant
//                    with explicit release, request-drop and hold-timeout exits.
// Revision         : 1.0
// ============================================================================
module rr_grant_arbiter #(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] grant_idx,
    output logic       grant_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? CNT_W'(MAX_HOLD - 1) : '0;

    state_t           state_q, state_d;
    logic [3:0]       grant_q, grant_d;
    logic [1:0]       grant_idx_q, grant_idx_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q, timeout_d;

    logic [1:0]       sel_idx;
    logic [1:0]       cand;
    logic             hold_limit;
    logic             owner_req;

    // Scan from the highest offset down so the lowest offset from ptr_q wins.
    always_comb begin
        sel_idx = ptr_q;
        cand    = '0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                sel_idx = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        timeout_d   = 1'b0;
        hold_limit  = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
        owner_req   = req[grant_idx_q];

        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = GRANT;
                    grant_idx_d = sel_idx;
                    grant_d     = 4'b0001 << sel_idx;
                    hold_cnt_d  = '0;
                end
            end
            GRANT: begin
                if (done || !owner_req || hold_limit) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    ptr_d     = grant_idx_q + 2'd1;
                    // Flag only revocations the owner did not ask for.
                    timeout_d = !done && owner_req;
                end else if (MAX_HOLD != 0) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= '0;
            hold_cnt_q  <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_idx   = grant_idx_q;
    assign grant_valid = |grant_q;
    assign timeout     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rr_grant_arbiter : scoreboard bench for rr_grant_arbiter at MAX_HOLD 16/4/0
// Revision            : 1.0
// ============================================================================
module tb_rr_grant_arbiter;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] i;
        logic       v;
        logic       t;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_a = '0, req_b = '0, req_c = '0;
    logic       done_a = 1'b0, done_b = 1'b0, done_c = 1'b0;
    logic [3:0] g_a, g_b, g_c;
    logic [1:0] i_a, i_b, i_c;
    logic       v_a, v_b, v_c;
    logic       t_a, t_b, t_c;

    exp_t sb_q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    rr_grant_arbiter #(.MAX_HOLD(16)) u_a (
        .clk(clk), .rst(rst), .req(req_a), .done(done_a),
        .grant(g_a), .grant_idx(i_a), .grant_valid(v_a), .timeout(t_a));
    rr_grant_arbiter #(.MAX_HOLD(4)) u_b (
        .clk(clk), .rst(rst), .req(req_b), .done(done_b),
        .grant(g_b), .grant_idx(i_b), .grant_valid(v_b), .timeout(t_b));
    rr_grant_arbiter #(.MAX_HOLD(0)) u_c (
        .clk(clk), .rst(rst), .req(req_c), .done(done_c),
        .grant(g_c), .grant_idx(i_c), .grant_valid(v_c), .timeout(t_c));

    function automatic exp_t mk(input logic [3:0] g, input logic [1:0] i, input logic t);
        exp_t r;
        r.g = g; r.i = i; r.v = |g; r.t = t;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req_a = 4'b1111;
        repeat (2) tick();
        sb_q.push_back(mk(4'b0000, 2'd0, 1'b0));
        sb_q.push_back(mk(4'b0000, 2'd0, 1'b0));
        sb_q.push_back(mk(4'b0000, 2'd0, 1'b0));
        e = sb_q.pop_front(); n_cmp++;
        if ({g_a, i_a, v_a, t_a} !== e) begin
            n_bad++;
            $display("FAIL reset_a: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                     g_a, i_a, v_a, t_a, e.g, e.i, e.v, e.t);
        end
        e = sb_q.pop_front(); n_cmp++;
        if ({g_b, i_b, v_b, t_b} !== e) begin
            n_bad++;
            $display("FAIL reset_b: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                     g_b, i_b, v_b, t_b, e.g, e.i, e.v, e.t);
        end
        e = sb_q.pop_front(); n_cmp++;
        if ({g_c, i_c, v_c, t_c} !== e) begin
            n_bad++;
            $display("FAIL reset_c: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                     g_c, i_c, v_c, t_c, e.g, e.i, e.v, e.t);
        end
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(mk(4'b0001, 2'd0, 1'b0));
        tick();
        e = sb_q.pop_front(); n_cmp++;
        if ({g_a, i_a, v_a, t_a} !== e) begin
            n_bad++;
            $display("FAIL reset_first_grant: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                     g_a, i_a, v_a, t_a, e.g, e.i, e.v, e.t);
        end
    endtask

    // Starts with requester 0 owning; done pulsed on every GRANT cycle.
    task automatic test_rotation();
        logic [3:0] g_tab [8];
        logic [1:0] i_tab [8];
        g_tab = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        i_tab = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        req_a = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            done_a = (k % 2 == 0);
            sb_q.push_back(mk(g_tab[k], i_tab[k], 1'b0));
            tick();
            e = sb_q.pop_front(); n_cmp++;
            if ({g_a, i_a, v_a, t_a} !== e) begin
                n_bad++;
                $display("FAIL rotation[%0d]: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                         k, g_a, i_a, v_a, t_a, e.g, e.i, e.v, e.t);
            end
        end
        done_a = 1'b0;
    endtask

    // Owner drop, non-owner bits ignored while granted, pointer after exit.
    task automatic test_request_drop();
        logic [3:0] r_tab [5];
        logic [3:0] g_tab [5];
        logic [1:0] i_tab [5];
        r_tab = '{4'b0100, 4'b0100, 4'b0111, 4'b1001, 4'b1001};
        g_tab = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b1000};
        i_tab = '{2'd0, 2'd2, 2'd2, 2'd2, 2'd3};
        for (int k = 0; k < 5; k++) begin
            req_a = r_tab[k];
            sb_q.push_back(mk(g_tab[k], i_tab[k], 1'b0));
            tick();
            e = sb_q.pop_front(); n_cmp++;
            if ({g_a, i_a, v_a, t_a} !== e) begin
                n_bad++;
                $display("FAIL request_drop[%0d]: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                         k, g_a, i_a, v_a, t_a, e.g, e.i, e.v, e.t);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] r_tab [2];
        logic [3:0] g_tab [2];
        logic [1:0] i_tab [2];
        r_tab = '{4'b0000, 4'b0010};
        g_tab = '{4'b0000, 4'b0010};
        i_tab = '{2'd3, 2'd1};
        for (int k = 0; k < 2; k++) begin
            req_a = r_tab[k];
            sb_q.push_back(mk(g_tab[k], i_tab[k], 1'b0));
            tick();
            e = sb_q.pop_front(); n_cmp++;
            if ({g_a, i_a, v_a, t_a} !== e) begin
                n_bad++;
                $display("FAIL async_setup[%0d]: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                         k, g_a, i_a, v_a, t_a, e.g, e.i, e.v, e.t);
            end
        end
        #2;
        rst = 1'b1;
        sb_q.push_back(mk(4'b0000, 2'd0, 1'b0));
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if ({g_a, i_a, v_a, t_a} !== e) begin
            n_bad++;
            $display("FAIL async_midcycle: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                     g_a, i_a, v_a, t_a, e.g, e.i, e.v, e.t);
        end
        req_a = 4'b0110;
        @(negedge clk);
        rst = 1'b0;
        sb_q.push_back(mk(4'b0010, 2'd1, 1'b0));
        tick();
        e = sb_q.pop_front(); n_cmp++;
        if ({g_a, i_a, v_a, t_a} !== e) begin
            n_bad++;
            $display("FAIL async_regrant: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                     g_a, i_a, v_a, t_a, e.g, e.i, e.v, e.t);
        end
        req_a = 4'b0000;
        tick();
    endtask

    // MAX_HOLD=4: timeout pulse, sole-requester regrant, done masks timeout.
    task automatic test_timeout();
        logic [3:0] r_tab [12];
        logic       d_tab [12];
        logic [3:0] g_tab [12];
        logic       t_tab [12];
        r_tab = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100,
                  4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        d_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        g_tab = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100,
                  4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0000};
        t_tab = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int k = 0; k < 12; k++) begin
            req_b  = r_tab[k];
            done_b = d_tab[k];
            sb_q.push_back(mk(g_tab[k], 2'd2, t_tab[k]));
            tick();
            e = sb_q.pop_front(); n_cmp++;
            if ({g_b, i_b, v_b, t_b} !== e) begin
                n_bad++;
                $display("FAIL timeout[%0d]: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                         k, g_b, i_b, v_b, t_b, e.g, e.i, e.v, e.t);
            end
        end
        done_b = 1'b0;
    endtask

    task automatic test_timeout_disabled();
        req_c  = 4'b0001;
        done_c = 1'b0;
        for (int k = 0; k < 101; k++) begin
            if (k == 100) req_c = 4'b0000;
            sb_q.push_back(mk((k == 100) ? 4'b0000 : 4'b0001, 2'd0, 1'b0));
            tick();
            e = sb_q.pop_front(); n_cmp++;
            if ({g_c, i_c, v_c, t_c} !== e) begin
                n_bad++;
                $display("FAIL no_timeout[%0d]: got g=%b i=%0d v=%b t=%b, want g=%b i=%0d v=%b t=%b",
                         k, g_c, i_c, v_c, t_c, e.g, e.i, e.v, e.t);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_request_drop();
        test_async_reset();
        test_timeout();
        test_timeout_disabled();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
